seg_scanner: RTL

SEG_SCANNER -- requirements
Module: seg_scanner

---
 rtl/seg_scanner.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/seg_scanner.sv
// -----------------------------------------------------------------------------
// seg_scanner
//
// Time-multiplexed driver for a NUM_DIGITS-digit 7-segment panel. Each digit
// gets a slot of SCAN_DIV clock cycles. The first BLANK_CYCLES cycles of each
// slot are blanked to hide ghosting while the digit drivers switch over. The
// panel only ever shows a shadow copy of hex_in. That copy is refreshed once
// per frame, at the wrap from the last digit back to digit 0, unless hold is
// high.
//
// Configuration macro:
//   SEG_SCANNER_BLANK_EN : when defined, the per-slot blanking window is
//                          compiled in. When undefined, BLANK_CYCLES is
//                          ignored and every RUN cycle drives the digit.
//
// Parameters:
//   NUM_DIGITS   : number of multiplexed digits (>= 2)
//   SCAN_DIV     : clock cycles per digit slot (>= 2)
//   BLANK_CYCLES : blanked cycles at the start of each slot (< SCAN_DIV)
//
// Ports:
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset
//   hex_in     : segment patterns; digit k is at [8k+7:8k]
//                (bit7 = seg a ... bit0 = dp, 1 = lit)
//   hold       : suppresses the frame-boundary reload of the shadow
//   seg_out    : registered segment bus, 1 = lit
//   dig_sel    : registered one-hot digit enable, all-zero while blanked
//   frame_done : registered single-cycle pulse on the first cycle of each
//                new frame (not on the first frame after reset)
// -----------------------------------------------------------------------------
module seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 10000,
    parameter int BLANK_CYCLES = 200
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS*8-1:0] hex_in,
    input  logic                    hold,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
`ifdef SEG_SCANNER_BLANK_EN
    localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYCLES);
`endif

    // Parameter sanity check at elaboration time.
    generate
        if (BLANK_CYCLES >= SCAN_DIV || NUM_DIGITS < 2 || SCAN_DIV < 2) begin : g_bad_params
            $error("seg_scanner: need NUM_DIGITS>=2, SCAN_DIV>=2, BLANK_CYCLES<SCAN_DIV");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state,  state_nxt;
    logic [IDX_W-1:0]        idx,    idx_nxt;
    logic [DIV_W-1:0]        div,    div_nxt;
    logic [NUM_DIGITS*8-1:0] shadow, shadow_nxt;
    logic [7:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   dig_nxt;
    logic                    frame_nxt;
    logic                    blank;

    // State and output registers. Outputs are registered so they change on
    // the same edge as the scan position they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            div        <= '0;
            shadow     <= '0;
            seg_out    <= '0;
            dig_sel    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            div        <= div_nxt;
            shadow     <= shadow_nxt;
            seg_out    <= seg_nxt;
            dig_sel    <= dig_nxt;
            frame_done <= frame_nxt;
        end
    end

    // Next position, shadow and outputs. The outputs are derived from the
    // *next* position and shadow, so the registered outputs always match the
    // position registered on the same edge.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        div_nxt    = div;
        shadow_nxt = shadow;
        frame_nxt  = 1'b0;
        seg_nxt    = '0;
        dig_nxt    = '0;
        blank      = 1'b0;

        case (state)
            IDLE: begin
                // Leaving reset: start at (0,0) with a fresh shadow. The
                // hold input is deliberately ignored here, and no frame_done.
                state_nxt  = RUN;
                idx_nxt    = '0;
                div_nxt    = '0;
                shadow_nxt = hex_in;
            end
            RUN: begin
                if (div == DIV_LAST) begin
                    div_nxt = '0;
                    if (idx == IDX_LAST) begin
                        idx_nxt   = '0;
                        frame_nxt = 1'b1;
                        if (!hold) begin
                            shadow_nxt = hex_in;
                        end
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end else begin
                    div_nxt = div + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

`ifdef SEG_SCANNER_BLANK_EN
        blank = (div_nxt < BLANK_LIM);
`else
        blank = 1'b0;
`endif

        if (state_nxt == RUN && !blank) begin
            seg_nxt = shadow_nxt[{idx_nxt, 3'b000} +: 8];
            dig_nxt = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_nxt;
        end
    end

endmodule
